pwm_fade_controller: RTL and testbench
======================================

Name: pwm_fade_controller

Overview:
- Sequencer that drives the `duty` input of the existing `pwm` block to produce a breathing / fade waveform.
- Phase order: rise, hold-high, fall, hold-low.
- Consumes the same `step` pulse from `pulse_generator` that advances `pwm`.
- Changes duty only on PWM period boundaries, so every PWM period is glitch-free.
- Supports one-shot and continuous operation with a graceful stop.

Parameters:
- N, 4, duty width; must equal the `pwm` N. A PWM period is 2^N step pulses.
- RATE_W, 8, width of the rate field.
- HOLD_W, 8, width of the hold-count fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; low freezes all state, counters and outputs.
- step  in  1  single-cycle pulse from `pulse_generator`, shared with `pwm`.
- start  in  1  single-cycle request to begin a fade cycle.
- stop  in  1  single-cycle request to end after the current cycle.
- continuous  in  1  1 = loop forever, 0 = one-shot. Sampled at start.
- rate  in  RATE_W  PWM periods per duty increment/decrement. 0 is treated as 1. Sampled at start.
- hold_high  in  HOLD_W  PWM periods held at full duty. Sampled at start.
- hold_low  in  HOLD_W  PWM periods held at 0 at cycle end. Sampled at start.
- duty  out  N  duty value to `pwm`. Registered.
- busy  out  1  high in any non-IDLE state.
- cycle_done  out  1  one-cycle pulse when a fade cycle completes.

Behaviour:
- Reset (`rst` sampled high at posedge):
  - state IDLE; duty=0; busy=0; cycle_done=0.
  - step_cnt=0, rate_cnt=0, hold_cnt=0; stop_pending=0.
  - Config shadow registers cleared.
  - A reset mid-cycle aborts immediately. No graceful ramp.
- Gating: when `ena`=0, nothing updates. `step`, `start` and `stop` are ignored, not queued. cycle_done=0.
- Period tracker:
  - step_cnt (N bits) increments on each step and wraps from 2^N-1 to 0.
  - It is free-running from reset and is never cleared by `start`, which keeps it aligned with the `pwm` counter.
  - boundary = step && step_cnt == 2^N-1.
  - All duty/state updates occur only on boundary. The new duty is visible the cycle after the boundary.
- IDLE:
  - duty=0.
  - start → RISE on the next cycle, latching rate/hold_high/hold_low/continuous; rate_cnt=0; stop_pending=0.
  - stop in IDLE is ignored.
- RISE:
  - On each boundary, rate_cnt++.
  - When rate_cnt reaches eff_rate-1: rate_cnt=0 and duty++.
  - If the new duty = 2^N-1: go to HOLD_HIGH (hold_cnt=0), or to FALL if hold_high=0.
- HOLD_HIGH:
  - On each boundary, hold_cnt++.
  - When hold_cnt reaches hold_high-1: go to FALL (rate_cnt=0).
- FALL:
  - Mirror of RISE with duty--.
  - When the new duty = 0: go to HOLD_LOW, or end the cycle if hold_low=0.
- HOLD_LOW:
  - Counts hold_low boundaries like HOLD_HIGH, then ends the cycle.
- End of cycle:
  - cycle_done pulses for one clk on the transition.
  - If continuous && !stop_pending: go to RISE with rate_cnt=0.
  - Otherwise go to IDLE.
- Stop and start interactions:
  - stop while busy sets stop_pending. It never truncates a ramp.
  - start while busy is ignored.
  - If start and stop assert in the same cycle in IDLE, start wins and stop_pending=0.
- Widths and arithmetic:
  - duty never wraps; ramp endpoints are exactly 0 and 2^N-1.
  - Counter comparisons are done at full width. No overflow is possible.
- Cycle-length formula, with R = max(rate,1): one cycle = 2·(2^N-1)·R + hold_high + hold_low boundaries.

Decomposition:
- Package `pwm_ctrl_pkg` holds:
  - typedef enum logic [2:0] fade_state_t {S_IDLE, S_RISE, S_HOLD_HIGH, S_FALL, S_HOLD_LOW}
  - helper function eff_rate(rate), which returns 1 when rate=0.
- One sub-module, `pwm_period_tracker` (params N; ports clk, rst, ena, step, boundary):
  - Contains step_cnt and the boundary decode.
  - Reusable by other controllers sharing the `pwm` timebase.

Test Plan:
- One-shot: N=4, rate=1, hold_high=2, hold_low=1, continuous=0, start pulse.
  - duty goes 1..15 on boundaries 1–15 and holds 15 for boundaries 16–17.
  - duty goes 14..0 on boundaries 18–32.
  - cycle_done on boundary 33, i.e. after 33·16 step pulses; then busy=0 and duty=0.
- Rate scaling: rate=3, holds=0.
  - duty increments every 3rd boundary.
  - Peak 15 is reached at boundary 45; cycle_done at boundary 90.
  - rate=0 gives the same timing as rate=1.
- Continuous plus stop: continuous=1, rate=1, holds=0.
  - After the first cycle_done, RISE restarts immediately.
  - stop asserted at duty=7 during RISE → ramp completes, cycle_done fires, state goes to IDLE, busy=0.
- Enable freeze: during FALL at duty=9, drop ena for 100 cycles while step toggles.
  - duty stays 9 and state is unchanged.
  - After ena returns, the boundary phase resumes with no skipped or extra step counted.
- Reset and collisions:
  - rst mid-HOLD_HIGH → next cycle duty=0, busy=0, cycle_done=0.
  - start while busy: no effect on timing.
  - Simultaneous start+stop in IDLE → cycle runs to completion in one-shot mode, then IDLE.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM fade sequencer.
package pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RISE,
    S_HOLD_HIGH,
    S_FALL,
    S_HOLD_LOW
  } fade_state_t;

  // A rate of zero would never advance the ramp, so it behaves like one.
  function automatic logic [31:0] eff_rate(input logic [31:0] rate);
    return (rate == 32'd0) ? 32'd1 : rate;
  endfunction

endpackage

// File: rtl/pwm_period_tracker.sv
// Tracks the pwm step counter and flags the last step of each PWM period.
module pwm_period_tracker #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic step,
  output logic boundary
);

  logic [N-1:0] step_cnt;

  // Free-running step counter, mirrors the pwm block's own counter.
  always_ff @(posedge clk) begin
    if (rst)
      step_cnt <= '0;
    else if (ena && step)
      step_cnt <= step_cnt + 1'b1;
  end

  assign boundary = ena && step && (step_cnt == {N{1'b1}});

endmodule

// File: rtl/pwm_fade_controller.sv
// Breathing-waveform sequencer: ramps pwm duty up, holds, ramps down, holds,
// updating duty only on PWM period boundaries.
module pwm_fade_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int N      = 4,
  parameter int RATE_W = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              step,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [RATE_W-1:0] rate,
  input  logic [HOLD_W-1:0] hold_high,
  input  logic [HOLD_W-1:0] hold_low,
  output logic [N-1:0]      duty,
  output logic              busy,
  output logic              cycle_done
);

  localparam logic [N-1:0] DUTY_MAX = '1;

  fade_state_t       state_q, state_d;
  logic [N-1:0]      duty_d;
  logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_d;

  // Configuration shadow, captured at start
  logic              cont_q, cont_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [HOLD_W-1:0] hh_q, hh_d;
  logic [HOLD_W-1:0] hl_q, hl_d;

  logic              boundary;
  logic              end_cycle;
  logic [RATE_W-1:0] rate_last;

  pwm_period_tracker #(.N(N)) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .step     (step),
    .boundary (boundary)
  );

  assign rate_last = RATE_W'(eff_rate(32'(rate_q)) - 32'd1);
  assign busy      = (state_q != S_IDLE);

  // State and datapath registers; ena low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      duty        <= '0;
      rate_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      stop_pend_q <= 1'b0;
      cont_q      <= 1'b0;
      rate_q      <= '0;
      hh_q        <= '0;
      hl_q        <= '0;
      cycle_done  <= 1'b0;
    end else begin
      // done_d can only rise on a boundary, which already implies ena
      cycle_done <= done_d;
      if (ena) begin
        state_q     <= state_d;
        duty        <= duty_d;
        rate_cnt_q  <= rate_cnt_d;
        hold_cnt_q  <= hold_cnt_d;
        stop_pend_q <= stop_pend_d;
        cont_q      <= cont_d;
        rate_q      <= rate_d;
        hh_q        <= hh_d;
        hl_q        <= hl_d;
      end
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    duty_d      = duty;
    rate_cnt_d  = rate_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    stop_pend_d = stop_pend_q;
    cont_d      = cont_q;
    rate_d      = rate_q;
    hh_d        = hh_q;
    hl_d        = hl_q;
    done_d      = 1'b0;
    end_cycle   = 1'b0;

    // Stop only ever ends things at a cycle boundary, never mid-ramp
    if (stop && state_q != S_IDLE)
      stop_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        duty_d = '0;
        if (start) begin
          state_d     = S_RISE;
          rate_cnt_d  = '0;
          stop_pend_d = 1'b0;
          cont_d      = continuous;
          rate_d      = rate;
          hh_d        = hold_high;
          hl_d        = hold_low;
        end
      end

      S_RISE: if (boundary) begin
        if (rate_cnt_q == rate_last) begin
          rate_cnt_d = '0;
          duty_d     = duty + 1'b1;
          if (duty == DUTY_MAX - 1'b1) begin
            hold_cnt_d = '0;
            state_d    = (hh_q == '0) ? S_FALL : S_HOLD_HIGH;
          end
        end else begin
          rate_cnt_d = rate_cnt_q + 1'b1;
        end
      end

      S_HOLD_HIGH: if (boundary) begin
        if (hold_cnt_q == hh_q - HOLD_W'(1)) begin
          state_d    = S_FALL;
          rate_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      S_FALL: if (boundary) begin
        if (rate_cnt_q == rate_last) begin
          rate_cnt_d = '0;
          duty_d     = duty - 1'b1;
          if (duty == N'(1)) begin
            hold_cnt_d = '0;
            if (hl_q == '0)
              end_cycle = 1'b1;
            else
              state_d = S_HOLD_LOW;
          end
        end else begin
          rate_cnt_d = rate_cnt_q + 1'b1;
        end
      end

      S_HOLD_LOW: if (boundary) begin
        if (hold_cnt_q == hl_q - HOLD_W'(1))
          end_cycle = 1'b1;
        else
          hold_cnt_d = hold_cnt_q + 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Cycle complete: loop again or retire to IDLE
    if (end_cycle) begin
      done_d      = 1'b1;
      rate_cnt_d  = '0;
      stop_pend_d = 1'b0;
      if (cont_q && !(stop_pend_q || stop))
        state_d = S_RISE;
      else
        state_d = S_IDLE;
    end
  end

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Self-checking bench for pwm_fade_controller against a duty-sequence model.
module tb_pwm_fade_controller;
  localparam int N = 4, RATE_W = 8, HOLD_W = 8;
  localparam int DMAX = (1 << N) - 1;

  logic clk = 1'b0;
  logic rst, ena, step, start, stop, continuous;
  logic [RATE_W-1:0] rate;
  logic [HOLD_W-1:0] hold_high, hold_low;
  logic [N-1:0] duty;
  logic busy, cycle_done;

  int n_cmp = 0, n_bad = 0;
  int mcnt = 0;
  bit bnd;
  int expq[$];

  always #5 clk = ~clk;

  pwm_fade_controller #(.N(N), .RATE_W(RATE_W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .step(step), .start(start), .stop(stop),
    .continuous(continuous), .rate(rate), .hold_high(hold_high),
    .hold_low(hold_low), .duty(duty), .busy(busy), .cycle_done(cycle_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: apply step, track period phase, release pulse inputs.
  task automatic clk_step(input bit s);
    step = s;
    @(posedge clk);
    bnd = !rst && ena && s && (mcnt == DMAX);
    if (rst) mcnt = 0;
    else if (ena && s) mcnt = (mcnt + 1) % (DMAX + 1);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Duty value after each boundary of one full fade cycle.
  task automatic build(input int r, input int hh, input int hl);
    int R;
    R = (r == 0) ? 1 : r;
    expq.delete();
    for (int d = 1; d <= DMAX; d++)
      for (int i = 0; i < R; i++) expq.push_back((i == R - 1) ? d : d - 1);
    repeat (hh) expq.push_back(DMAX);
    for (int d = DMAX - 1; d >= 0; d--)
      for (int i = 0; i < R; i++) expq.push_back((i == R - 1) ? d : d + 1);
    repeat (hl) expq.push_back(0);
  endtask

  task automatic begin_fade(input int r, input int hh, input int hl, input bit cont,
                            input bit with_stop);
    rate = RATE_W'(r); hold_high = HOLD_W'(hh); hold_low = HOLD_W'(hl);
    continuous = cont;
    start = 1'b1; stop = with_stop;
    clk_step($urandom_range(0, 1) == 1);
    // scramble the live inputs: the latched copy must be used
    rate = RATE_W'($urandom); hold_high = HOLD_W'($urandom);
    hold_low = HOLD_W'($urandom); continuous = ~cont;
    chk("start_busy", busy, 1);
    chk("start_duty", duty, 0);
  endtask

  // Run one fade cycle, checking every clock against the model.
  task automatic do_cycle(input int r, input int hh, input int hl, input bit more,
                          input int stop_duty, input int poke_k, input int freeze_duty,
                          input int rst_k);
    int R, k, cur, cyc, budget;
    bit stopped, froze, poked;
    R = (r == 0) ? 1 : r;
    build(r, hh, hl);
    k = 0; cur = 0; cyc = 0; stopped = 0; froze = 0; poked = 0;
    budget = expq.size() * 80 + 400;
    while (k < expq.size()) begin
      if (cyc++ > budget) begin
        chk("timeout_boundaries", k, expq.size());
        return;
      end
      if (stop_duty >= 0 && !stopped && cur == stop_duty && k < DMAX * R) begin
        stop = 1'b1; stopped = 1;
      end
      if (poke_k >= 0 && !poked && k == poke_k) begin
        start = 1'b1; poked = 1;
      end
      if (freeze_duty >= 0 && !froze && k >= DMAX * R + hh && cur == freeze_duty) begin
        froze = 1;
        ena = 1'b0;
        repeat (100) begin
          start = $urandom_range(0, 1) == 1;
          stop  = $urandom_range(0, 1) == 1;
          clk_step($urandom_range(0, 1) == 1);
          chk("freeze_duty", duty, cur);
          chk("freeze_done", cycle_done, 0);
          chk("freeze_busy", busy, 1);
        end
        ena = 1'b1;
      end
      clk_step($urandom_range(0, 3) != 0);
      if (bnd) begin
        k++;
        cur = expq[k-1];
      end
      chk("duty", duty, cur);
      chk("cycle_done", cycle_done, (bnd && k == expq.size()) ? 1 : 0);
      if (k < expq.size()) chk("busy", busy, 1);
      if (rst_k >= 0 && bnd && k == rst_k) begin
        rst = 1'b1;
        clk_step(1'b1);
        rst = 1'b0;
        chk("rst_duty", duty, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", cycle_done, 0);
        return;
      end
    end
    chk("end_busy", busy, more ? 1 : 0);
    if (!more) begin
      clk_step(1'b1);
      chk("post_done", cycle_done, 0);
      chk("post_duty", duty, 0);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; step = 1'b0; start = 1'b0; stop = 1'b0;
    continuous = 1'b0; rate = '0; hold_high = '0; hold_low = '0;
    repeat (3) clk_step(1'b0);
    rst = 1'b0;
    chk("reset_duty", duty, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", cycle_done, 0);

    // stop in IDLE is ignored
    stop = 1'b1;
    clk_step(1'b1);
    chk("idle_stop_busy", busy, 0);

    // one-shot, rate 1, holds 2/1
    begin_fade(1, 2, 1, 1'b0, 1'b0);
    do_cycle(1, 2, 1, 1'b0, -1, -1, -1, -1);

    // rate scaling, rate 0 behaves like rate 1
    begin_fade(3, 0, 0, 1'b0, 1'b0);
    do_cycle(3, 0, 0, 1'b0, -1, -1, -1, -1);
    begin_fade(0, 0, 0, 1'b0, 1'b0);
    do_cycle(0, 0, 0, 1'b0, -1, -1, -1, -1);

    // continuous, then graceful stop at duty 7 on the second pass
    begin_fade(1, 0, 0, 1'b1, 1'b0);
    do_cycle(1, 0, 0, 1'b1, -1, -1, -1, -1);
    do_cycle(1, 0, 0, 1'b0, 7, -1, -1, -1);

    // enable freeze during FALL at 9, plus an ignored start while busy
    begin_fade(1, 1, 2, 1'b0, 1'b0);
    do_cycle(1, 1, 2, 1'b0, -1, 5, 9, -1);

    // reset in the middle of HOLD_HIGH
    begin_fade(2, 6, 0, 1'b0, 1'b0);
    do_cycle(2, 6, 0, 1'b0, -1, -1, -1, 2 * DMAX + 3);

    // start+stop together in IDLE: start wins, so a continuous run keeps going
    begin_fade(1, 1, 1, 1'b1, 1'b1);
    do_cycle(1, 1, 1, 1'b1, -1, -1, -1, -1);
    do_cycle(1, 1, 1, 1'b0, 3, -1, -1, -1);
    // same collision in one-shot mode
    begin_fade(1, 0, 1, 1'b0, 1'b1);
    do_cycle(1, 0, 1, 1'b0, -1, -1, -1, -1);

    // randomized configurations
    for (int t = 0; t < 3; t++) begin
      int r, hh, hl;
      r  = $urandom_range(0, 2);
      hh = $urandom_range(0, 4);
      hl = $urandom_range(0, 4);
      begin_fade(r, hh, hl, 1'b0, 1'b0);
      do_cycle(r, hh, hl, 1'b0, -1, -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
